// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with a 2-bit history counter per entry.
// Fetch side: combinational lookup of pc_f gives a taken/target prediction.
// Execute side: a resolved branch or jump trains the tables, flags a mispredict,
// supplies the correct next PC, and advances the performance counters.
module branch_predictor #(
  parameter int IDX_BITS = 6,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_f,
  output logic             pred_taken_f,
  output logic [31:0]      pred_pc_f,
  input  logic             upd_valid_e,
  input  logic             upd_is_jump_e,
  input  logic [31:0]      upd_pc_e,
  input  logic [31:0]      upd_pc_plus4_e,
  input  logic             upd_taken_e,
  input  logic [31:0]      upd_target_e,
  input  logic             pred_taken_e,
  input  logic [31:0]      pred_pc_e,
  output logic             mispredict_e,
  output logic [31:0]      redirect_pc_e,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 32 - IDX_BITS - 2;

  // Counter that climbs towards strongly-taken and stops there.
  function automatic logic [1:0] ctr_sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  // Counter that falls towards strongly-not-taken and stops there.
  function automatic logic [1:0] ctr_sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  // Valid and counter bits are cleared by reset; tag/target/jump are only
  // ever observed through a valid bit, so they carry no reset.
  logic [ENTRIES-1:0] valid_r;
  logic [1:0]         ctr_r    [ENTRIES];
  logic [TAG_W-1:0]   tag_r    [ENTRIES];
  logic [31:0]        target_r [ENTRIES];
  logic [ENTRIES-1:0] jump_r;

  logic [IDX_BITS-1:0] f_idx_s;
  logic [TAG_W-1:0]    f_tag_s;
  logic                f_hit_s;
  logic [IDX_BITS-1:0] u_idx_s;
  logic [TAG_W-1:0]    u_tag_s;
  logic                u_hit_s;
  logic [CNT_W-1:0]    branch_count_r;
  logic [CNT_W-1:0]    mispredict_count_r;
  logic                unused_pc_lsb_s;

  // Instructions are word aligned; the two low PC bits never select anything.
  assign unused_pc_lsb_s = ^{pc_f[1:0], upd_pc_e[1:0]};

  assign f_idx_s = pc_f[IDX_BITS+1:2];
  assign f_tag_s = pc_f[31:IDX_BITS+2];
  assign u_idx_s = upd_pc_e[IDX_BITS+1:2];
  assign u_tag_s = upd_pc_e[31:IDX_BITS+2];

  // Fetch lookup reads the pre-update table, so a same-cycle update is not bypassed.
  always_comb begin
    f_hit_s      = valid_r[f_idx_s] && (tag_r[f_idx_s] == f_tag_s);
    pred_taken_f = f_hit_s && (jump_r[f_idx_s] || ctr_r[f_idx_s][1]);
    if (pred_taken_f) begin
      pred_pc_f = target_r[f_idx_s];
    end else begin
      pred_pc_f = pc_f + 32'd4;
    end
  end

  // Execute-side hit check against the contents before this cycle's write.
  always_comb begin
    u_hit_s = valid_r[u_idx_s] && (tag_r[u_idx_s] == u_tag_s);
  end

  // Mispredict detection and the correct next PC for the resolved op.
  always_comb begin
    mispredict_e = upd_valid_e &&
                   ((pred_taken_e != upd_taken_e) ||
                    (upd_taken_e && (pred_pc_e != upd_target_e)));
    if (upd_taken_e) begin
      redirect_pc_e = upd_target_e;
    end else begin
      redirect_pc_e = upd_pc_plus4_e;
    end
  end

  // Valid bits and direction counters: train on resolution, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_r[i] <= 2'b01;
      end
    end else if (upd_valid_e) begin
      if (upd_taken_e) begin
        valid_r[u_idx_s] <= 1'b1;
        if (u_hit_s) begin
          ctr_r[u_idx_s] <= ctr_sat_inc(ctr_r[u_idx_s]);
        end else begin
          ctr_r[u_idx_s] <= upd_is_jump_e ? 2'b11 : 2'b10;
        end
      end else if (u_hit_s) begin
        ctr_r[u_idx_s] <= ctr_sat_dec(ctr_r[u_idx_s]);
      end
    end
  end

  // Tag/target/jump payload: written on every taken resolution (hit or allocate).
  always_ff @(posedge clk) begin
    if (!rst && upd_valid_e && upd_taken_e) begin
      tag_r[u_idx_s]    <= u_tag_s;
      target_r[u_idx_s] <= upd_target_e;
      jump_r[u_idx_s]   <= upd_is_jump_e;
    end
  end

  // Performance counters, free-running modulo 2**CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count_r     <= '0;
      mispredict_count_r <= '0;
    end else begin
      if (upd_valid_e) begin
        branch_count_r <= branch_count_r + CNT_W'(1);
      end
      if (mispredict_e) begin
        mispredict_count_r <= mispredict_count_r + CNT_W'(1);
      end
    end
  end

  assign branch_count     = branch_count_r;
  assign mispredict_count = mispredict_count_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a table-of-entries model checked on every
// negative clock edge, plus hand-computed literal expectations along the way.
module tb_branch_predictor;

  localparam int IB = 6;
  localparam int CW = 4;
  localparam int NE = 1 << IB;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   pc_f;
  logic          pred_taken_f;
  logic [31:0]   pred_pc_f;
  logic          upd_valid_e;
  logic          upd_is_jump_e;
  logic [31:0]   upd_pc_e;
  logic [31:0]   upd_pc_plus4_e;
  logic          upd_taken_e;
  logic [31:0]   upd_target_e;
  logic          pred_taken_e;
  logic [31:0]   pred_pc_e;
  logic          mispredict_e;
  logic [31:0]   redirect_pc_e;
  logic [CW-1:0] branch_count;
  logic [CW-1:0] mispredict_count;

  int checks   = 0;
  int failures = 0;

  branch_predictor #(.IDX_BITS(IB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .pc_f(pc_f),
    .pred_taken_f(pred_taken_f), .pred_pc_f(pred_pc_f),
    .upd_valid_e(upd_valid_e), .upd_is_jump_e(upd_is_jump_e),
    .upd_pc_e(upd_pc_e), .upd_pc_plus4_e(upd_pc_plus4_e),
    .upd_taken_e(upd_taken_e), .upd_target_e(upd_target_e),
    .pred_taken_e(pred_taken_e), .pred_pc_e(pred_pc_e),
    .mispredict_e(mispredict_e), .redirect_pc_e(redirect_pc_e),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  // Model: one record per table slot, counter held as a plain integer 0..3.
  typedef struct {
    bit          v;
    int unsigned tag;
    int unsigned tgt;
    bit          j;
    int          ctr;
  } ent_t;

  ent_t        m [NE];
  int unsigned m_bc = 0;
  int unsigned m_mc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_misp();
    return upd_valid_e && ((pred_taken_e != upd_taken_e) ||
                           (upd_taken_e && (pred_pc_e != upd_target_e)));
  endfunction

  // Model state advance: mirrors the architectural training rules on each edge.
  always @(posedge clk or posedge rst) begin
    int unsigned i;
    bit          hit;
    if (rst) begin
      for (int k = 0; k < NE; k++) begin
        m[k].v   <= 1'b0;
        m[k].ctr <= 1;
      end
      m_bc <= 0;
      m_mc <= 0;
    end else if (upd_valid_e) begin
      i   = (upd_pc_e / 4) % NE;
      hit = m[i].v && (m[i].tag == upd_pc_e / (4 * NE));
      if (upd_taken_e) begin
        m[i].v   <= 1'b1;
        m[i].tag <= upd_pc_e / (4 * NE);
        m[i].tgt <= upd_target_e;
        m[i].j   <= upd_is_jump_e;
        if (hit) m[i].ctr <= (m[i].ctr < 3) ? m[i].ctr + 1 : 3;
        else     m[i].ctr <= upd_is_jump_e ? 3 : 2;
      end else if (hit) begin
        m[i].ctr <= (m[i].ctr > 0) ? m[i].ctr - 1 : 0;
      end
      m_bc <= (m_bc + 1) % (1 << CW);
      if (exp_misp()) m_mc <= (m_mc + 1) % (1 << CW);
    end
  end

  // Compare process: every negative edge, all outputs against the model.
  always @(negedge clk) begin
    int unsigned i;
    bit          hit;
    bit          pt;
    i   = (pc_f / 4) % NE;
    hit = m[i].v && (m[i].tag == pc_f / (4 * NE));
    pt  = hit && (m[i].j || m[i].ctr >= 2);
    chk("model_pred_taken_f", {31'd0, pred_taken_f}, {31'd0, pt});
    chk("model_pred_pc_f", pred_pc_f, pt ? m[i].tgt : pc_f + 32'd4);
    chk("model_mispredict_e", {31'd0, mispredict_e}, {31'd0, exp_misp()});
    chk("model_redirect_pc_e", redirect_pc_e, upd_taken_e ? upd_target_e : upd_pc_plus4_e);
    chk("model_branch_count", 32'(branch_count), m_bc);
    chk("model_mispredict_count", 32'(mispredict_count), m_mc);
  end

  task automatic idle();
    upd_valid_e    = 1'b0;
    upd_is_jump_e  = 1'b0;
    upd_pc_e       = 32'd0;
    upd_pc_plus4_e = 32'd4;
    upd_taken_e    = 1'b0;
    upd_target_e   = 32'd0;
    pred_taken_e   = 1'b0;
    pred_pc_e      = 32'd4;
  endtask

  task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                     input bit jmp, input bit pt, input logic [31:0] ppc);
    upd_valid_e    = 1'b1;
    upd_is_jump_e  = jmp;
    upd_pc_e       = pc;
    upd_pc_plus4_e = pc + 32'd4;
    upd_taken_e    = tk;
    upd_target_e   = tgt;
    pred_taken_e   = pt;
    pred_pc_e      = ppc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    pc_f = 32'h100;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // Cold table: fall-through prediction, counters clear.
    settle();
    chk("reset_pred_taken", {31'd0, pred_taken_f}, 32'd0);
    chk("reset_pred_pc", pred_pc_f, 32'h104);
    chk("reset_branch_count", 32'(branch_count), 32'd0);
    chk("reset_mispredict_count", 32'(mispredict_count), 32'd0);
    tick();

    // Taken branch 0x100 -> 0x80, predicted not taken; lookup this cycle is still old.
    upd(32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h104);
    settle();
    chk("alloc_mispredict", {31'd0, mispredict_e}, 32'd1);
    chk("alloc_redirect", redirect_pc_e, 32'h80);
    chk("alloc_same_cycle_old", {31'd0, pred_taken_f}, 32'd0);
    tick();
    idle();
    settle();
    chk("alloc_pred_taken", {31'd0, pred_taken_f}, 32'd1);
    chk("alloc_pred_pc", pred_pc_f, 32'h80);
    chk("alloc_branch_count", 32'(branch_count), 32'd1);
    chk("alloc_mispredict_count", 32'(mispredict_count), 32'd1);
    tick();

    // Not taken three times: 10 -> 01 -> 00 -> 00.
    upd(32'h100, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80);
    settle();
    chk("nt1_mispredict", {31'd0, mispredict_e}, 32'd1);
    chk("nt1_redirect", redirect_pc_e, 32'h104);
    tick();
    idle();
    settle();
    chk("nt1_pred_taken", {31'd0, pred_taken_f}, 32'd0);
    chk("nt1_pred_pc", pred_pc_f, 32'h104);
    tick();
    upd(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h104);
    settle();
    chk("nt2_no_mispredict", {31'd0, mispredict_e}, 32'd0);
    tick();
    tick();
    idle();
    settle();
    chk("nt3_saturated_low", {31'd0, pred_taken_f}, 32'd0);
    tick();

    // JAL at 0x200 -> 0x400 takes over slot 0, then its alias 0x300 replaces it.
    upd(32'h200, 1'b1, 32'h400, 1'b1, 1'b0, 32'h204);
    tick();
    idle();
    pc_f = 32'h200;
    settle();
    chk("jal_pred_taken", {31'd0, pred_taken_f}, 32'd1);
    chk("jal_pred_pc", pred_pc_f, 32'h400);
    tick();
    upd(32'h300, 1'b1, 32'h500, 1'b0, 1'b0, 32'h304);
    tick();
    idle();
    settle();
    chk("alias_evicts_taken", {31'd0, pred_taken_f}, 32'd0);
    chk("alias_evicts_pc", pred_pc_f, 32'h204);
    pc_f = 32'h300;
    #1;
    chk("alias_pred_pc", pred_pc_f, 32'h500);
    tick();

    // Taken twice on 0x300: 10 -> 11 -> 11, new target; one not-taken leaves 10.
    upd(32'h300, 1'b1, 32'h600, 1'b0, 1'b1, 32'h500);
    tick();
    upd(32'h300, 1'b1, 32'h600, 1'b0, 1'b1, 32'h600);
    settle();
    chk("retarget_no_mispredict", {31'd0, mispredict_e}, 32'd0);
    tick();
    upd(32'h300, 1'b0, 32'h0, 1'b0, 1'b1, 32'h600);
    tick();
    idle();
    settle();
    chk("sat_high_pred_taken", {31'd0, pred_taken_f}, 32'd1);
    chk("sat_high_pred_pc", pred_pc_f, 32'h600);
    tick();

    // Same-cycle lookup/update of 0x300: old (10) now, new (01) next cycle.
    upd(32'h300, 1'b0, 32'h0, 1'b0, 1'b1, 32'h600);
    settle();
    chk("same_cycle_old_taken", {31'd0, pred_taken_f}, 32'd1);
    tick();
    idle();
    settle();
    chk("same_cycle_new_taken", {31'd0, pred_taken_f}, 32'd0);
    chk("same_cycle_new_pc", pred_pc_f, 32'h304);
    tick();

    // Retrain, then async reset between edges must wipe it immediately.
    upd(32'h300, 1'b1, 32'h700, 1'b0, 1'b0, 32'h304);
    tick();
    idle();
    settle();
    chk("pre_rst_pred_pc", pred_pc_f, 32'h700);
    rst = 1'b1;
    #1;
    chk("async_rst_pred_taken", {31'd0, pred_taken_f}, 32'd0);
    chk("async_rst_pred_pc", pred_pc_f, 32'h304);
    chk("async_rst_branch_count", 32'(branch_count), 32'd0);
    chk("async_rst_mispredict_count", 32'(mispredict_count), 32'd0);
    tick();
    rst = 1'b0;

    // Seventeen mispredicting updates wrap both 4-bit counters to 1.
    pc_f = 32'h40;
    for (int n = 0; n < 17; n++) begin
      upd(32'h40, 1'b1, 32'h1000 + 32'(n) * 32'd4, 1'b0, 1'b0, 32'h44);
      tick();
    end
    idle();
    settle();
    chk("wrap_branch_count", 32'(branch_count), 32'd1);
    chk("wrap_mispredict_count", 32'(mispredict_count), 32'd1);
    chk("wrap_pred_pc", pred_pc_f, 32'h1040);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
